// File: rtl/phasecalc.sv
// Iterative vectoring-mode CORDIC: phase atan2(y, x) in Q8.10 degrees, one micro-rotation per clock.
// Optional PHASECALC_MAG_EN adds the gain-scaled magnitude output.
module phasecalc #(
  parameter int INPUTBITSIZE  = 13,
  parameter int OUTPUTBITSIZE = 19,
  parameter int ITERATIONS    = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  input  logic signed [INPUTBITSIZE-1:0]  x,
  input  logic signed [INPUTBITSIZE-1:0]  y,
  output logic signed [OUTPUTBITSIZE-1:0] angle
`ifdef PHASECALC_MAG_EN
  ,
  output logic [INPUTBITSIZE+1:0]         magnitude
`endif
);

  localparam int IW    = INPUTBITSIZE;
  localparam int OW    = OUTPUTBITSIZE;
  // Fractional guard bits below the integer datapath keep shift truncation
  // from dominating the angle error on short vectors.
  localparam int GUARD = 8;
  localparam int W     = IW + 3 + GUARD;
  localparam int CW    = $clog2(ITERATIONS + 1);

  localparam logic signed [OW-1:0] DEG90  = OW'(92160);
  localparam logic signed [OW-1:0] DEG180 = OW'(184320);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [W-1:0]   x_q, x_d, y_q, y_d;
  logic signed [OW-1:0]  z_q, z_d;
  logic signed [OW-1:0]  angle_q, angle_d;
  logic                  zero_q, zero_d, n180_q, n180_d;
  logic signed [W-1:0]   xs, ys, x_sh, y_sh;
  logic signed [OW-1:0]  step;

  function automatic logic signed [OW-1:0] atan_lut(input int i);
    case (i)
      0:  return OW'(46080);
      1:  return OW'(27203);
      2:  return OW'(14373);
      3:  return OW'(7296);
      4:  return OW'(3662);
      5:  return OW'(1833);
      6:  return OW'(917);
      7:  return OW'(458);
      8:  return OW'(229);
      9:  return OW'(115);
      10: return OW'(57);
      11: return OW'(29);
      12: return OW'(14);
      13: return OW'(7);
      14: return OW'(4);
      15: return OW'(2);
      default: return '0;
    endcase
  endfunction

  assign xs   = {{3{x[IW-1]}}, x, {GUARD{1'b0}}};
  assign ys   = {{3{y[IW-1]}}, y, {GUARD{1'b0}}};
  assign x_sh = x_q >>> cnt_q;
  assign y_sh = y_q >>> cnt_q;
  assign step = atan_lut(int'(cnt_q));

`ifdef PHASECALC_MAG_EN
  logic [IW+1:0] mag_q, mag_d;
  assign magnitude = mag_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    n180_d  = n180_q;
    angle_d = angle_q;
`ifdef PHASECALC_MAG_EN
    mag_d   = mag_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          zero_d  = (x == '0) && (y == '0);
          n180_d  = (y == '0) && x[IW-1];
          // Fold the left half-plane onto the right so the iterations converge.
          if (!x[IW-1]) begin
            x_d = xs;
            y_d = ys;
            z_d = '0;
          end else if (!y[IW-1]) begin
            x_d = ys;
            y_d = -xs;
            z_d = DEG90;
          end else begin
            x_d = -ys;
            y_d = xs;
            z_d = -DEG90;
          end
        end
      end
      RUN: begin
        if (cnt_q == CW'(ITERATIONS)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (zero_q)      angle_d = '0;
          else if (n180_q) angle_d = DEG180;
          else             angle_d = z_q;
`ifdef PHASECALC_MAG_EN
          mag_d = x_q[GUARD+IW+1:GUARD];
`endif
        end else begin
          if (!y_q[W-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + step;
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - step;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      n180_q  <= 1'b0;
      angle_q <= '0;
`ifdef PHASECALC_MAG_EN
      mag_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      n180_q  <= n180_d;
      angle_q <= angle_d;
`ifdef PHASECALC_MAG_EN
      mag_q   <= mag_d;
`endif
    end
  end

  assign busy  = (state_q == RUN);
  assign angle = angle_q;

endmodule

// File: tb/tb_phasecalc.sv
// Bench for phasecalc: directed table, handshake and reset corner cases, random sweep vs real-valued atan2.
module tb_phasecalc;

  localparam real PI = 3.14159265358979323846;

  logic               clock;
  logic               reset;
  logic               start;
  logic               busy;
  logic signed [12:0] x;
  logic signed [12:0] y;
  logic signed [18:0] angle;
`ifdef PHASECALC_MAG_EN
  logic [14:0]        magnitude;
`endif

  int errors = 0;
  int checks = 0;

  phasecalc dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .x     (x),
    .y     (y),
    .angle (angle)
`ifdef PHASECALC_MAG_EN
    ,
    .magnitude (magnitude)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string name;
    int    xi;
    int    yi;
    int    exp;
    int    tol;
  } vec_t;

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic int ref_angle(input int xi, input int yi);
    real a;
    if (xi == 0 && yi == 0) return 0;
    if (yi == 0 && xi < 0) return 184320;
    a = $atan2(real'(yi), real'(xi)) * 180.0 / PI * 1024.0;
    return int'(a);
  endfunction

  // Issued on a falling edge; returns the angle and the clocks from the start edge until busy drops.
  task automatic run_op(input int xi, input int yi, output int ang, output int lat);
    x     = 13'(xi);
    y     = 13'(yi);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat   = 0;
    while (busy && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    ang = int'(angle);
  endtask

  vec_t vecs[$];
  int   ang, lat, rx, ry;

  initial begin
    vecs.push_back('{"pos_x_axis",   1000,     0,       0, 51});
    vecs.push_back('{"pos_y_axis",      0,  1000,   92160, 51});
    vecs.push_back('{"neg_y_axis",      0, -1000,  -92160, 51});
    vecs.push_back('{"origin",          0,     0,       0,  0});
    vecs.push_back('{"diag_q1",      1000,  1000,   46080, 51});
    vecs.push_back('{"diag_q2",     -1000,  1000,  138240, 51});
    vecs.push_back('{"diag_q3",     -1000, -1000, -138240, 51});
    vecs.push_back('{"diag_q4",      1000, -1000,  -46080, 51});
    vecs.push_back('{"extreme_q3",  -4096, -4096, -138240, 51});
    vecs.push_back('{"extreme_q4",   4095, -4096,  -46087, 51});
    vecs.push_back('{"neg_x_axis",  -1000,     0,  184320,  0});

    reset = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    repeat (2) @(negedge clock);
    check_tol("reset_busy", int'(busy), 0, 0);
    check_tol("reset_angle", int'(angle), 0, 0);
    reset = 1'b1;
    @(negedge clock);

    // Back-to-back: each op starts on the same falling edge busy was seen low.
    foreach (vecs[i]) begin
      run_op(vecs[i].xi, vecs[i].yi, ang, lat);
      check_tol(vecs[i].name, ang, vecs[i].exp, vecs[i].tol);
      check_tol({vecs[i].name, "_latency"}, lat, 17, 0);
    end

    // Second start during busy must be ignored; angle holds until completion.
    x     = 13'(1000);
    y     = 13'(1000);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_tol("busy_rise", int'(busy), 1, 0);
    check_tol("angle_held_at_start", int'(angle), 184320, 0);
    repeat (2) @(negedge clock);
    x     = -13'sd1000;
    y     = -13'sd1000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    x     = '0;
    y     = '0;
    lat   = 3;
    while (busy && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check_tol("ignored_start_latency", lat, 17, 0);
    check_tol("ignored_start_angle", int'(angle), 46080, 51);

    // Reset five clocks into a run discards the work and clears the outputs at once.
    x     = 13'(500);
    y     = 13'(-300);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_tol("midrun_reset_busy", int'(busy), 0, 0);
    check_tol("midrun_reset_angle", int'(angle), 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_op(1000, 0, ang, lat);
    check_tol("after_reset_angle", ang, 0, 51);
    check_tol("after_reset_latency", lat, 17, 0);

    // Random sweep; vectors shorter than 64 LSB are left to the directed cases.
    for (int n = 0; n < 2000; n++) begin
      do begin
        rx = int'($urandom_range(8191)) - 4096;
        ry = int'($urandom_range(8191)) - 4096;
      end while (rx * rx + ry * ry < 4096);
      run_op(rx, ry, ang, lat);
      check_tol("sweep_angle", ang, ref_angle(rx, ry), 51);
      check_tol("sweep_latency", lat, 17, 0);
`ifdef PHASECALC_MAG_EN
      begin
        real r;
        r = 1.6468 * $sqrt(real'(rx * rx + ry * ry));
        check_tol("sweep_magnitude", int'(magnitude), int'(r), int'(r * 0.01) + 1);
      end
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
